// File: rtl/sysbus_pkg.sv
// rtl/sysbus_pkg.sv - shared system-bus types, tag layout and line geometry
//
// Contents:
//   state_t         responder FSM states
//   BEATS_PER_LINE  beats in one cache line (64-bit beats)
//   TAG_* / LINE_*  bit positions of the tag fields and line offset
//   SYSBUS_MEMORY   device code of the memory responder (value from Sysbus.defs)
package sysbus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACK   = 3'd1,
    LAT   = 3'd2,
    RDATA = 3'd3,
    WDATA = 3'd4
  } state_t;

  localparam int BEATS_PER_LINE = 8;
  localparam int BEAT_BITS      = 3;
  localparam int LINE_OFFSET_LO = 6;

  // Tag layout: [12] read/write, [11:8] device, [7:0] transaction id
  localparam int TAG_RW_BIT = 12;
  localparam int TAG_DEV_HI = 11;
  localparam int TAG_DEV_LO = 8;
  localparam int TAG_ID_HI  = 7;
  localparam int TAG_ID_LO  = 0;

  // Device code of the memory responder, mirrored from Sysbus.defs
  localparam logic [3:0] SYSBUS_MEMORY = 4'h1;

endpackage

// File: rtl/sysbus_mem_array.sv
// rtl/sysbus_mem_array.sv - backing store, one sync write port, one async read port
//
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe, sampled on posedge
//   wr_addr  in   write word index
//   wr_data  in   write data
//   rd_addr  in   read word index
//   rd_data  out  combinational read data
module sysbus_mem_array #(
  parameter int WORDS      = 4096,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  // Power-up contents are zero; reset deliberately leaves storage alone so
  // data survives a mid-burst reset.
  logic [DATA_WIDTH-1:0] mem [WORDS] = '{default: '0};

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sysbus_mem_responder.sv
// rtl/sysbus_mem_responder.sv - system-bus memory responder serving 8-beat line bursts
//
// Ports:
//   clk          in   clock, posedge
//   reset        in   synchronous active-low reset
//   bus_reqcyc   in   request / write-beat valid
//   bus_req      in   request address, or write data in a write burst
//   bus_reqtag   in   request tag {rw, device, id}
//   bus_reqack   out  request / write-beat accepted
//   bus_respcyc  out  read beat valid
//   bus_resp     out  read beat data
//   bus_resptag  out  tag of the burst being returned
//   bus_respack  in   read beat consumed
module sysbus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 4096,
  parameter int RESP_LATENCY   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int LAT_W = $clog2(RESP_LATENCY + 1);

  state_t                    state;
  logic [BEAT_BITS-1:0]      beat;
  logic [LAT_W-1:0]          lat_cnt;
  logic [IDX_W-1:0]          base_q;
  logic [BUS_TAG_WIDTH-1:0]  tag_q;
  logic                      reqack_q;
  logic                      respcyc_q;
  logic [BUS_DATA_WIDTH-1:0] resp_q;
  logic [BUS_TAG_WIDTH-1:0]  resptag_q;

  logic                      is_mem_req;
  logic [IDX_W-1:0]          req_base;
  logic                      wr_en;
  logic [IDX_W-1:0]          wr_idx;
  logic [BEAT_BITS-1:0]      rd_beat;
  logic [IDX_W-1:0]          rd_idx;
  logic [BUS_DATA_WIDTH-1:0] rd_data;

  assign is_mem_req = bus_reqtag[TAG_DEV_HI:TAG_DEV_LO] == SYSBUS_MEMORY;

  // Word index of beat 0: line number * 8, reduced modulo MEM_WORDS by truncation.
  assign req_base = IDX_W'({bus_req[BUS_DATA_WIDTH-1:LINE_OFFSET_LO], 3'b000});

  assign wr_en  = (state == WDATA) && bus_reqcyc;
  assign wr_idx = base_q + IDX_W'(beat);

  // The read port looks one beat ahead so resp_q can be loaded on the edge
  // that enters RDATA or consumes the current beat.
  assign rd_beat = (state == RDATA) ? beat + 3'd1 : 3'd0;
  assign rd_idx  = base_q + IDX_W'(rd_beat);

  sysbus_mem_array #(
    .WORDS      (MEM_WORDS),
    .DATA_WIDTH (BUS_DATA_WIDTH),
    .ADDR_WIDTH (IDX_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_idx),
    .wr_data (bus_req),
    .rd_addr (rd_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      beat      <= '0;
      lat_cnt   <= '0;
      base_q    <= '0;
      tag_q     <= '0;
      reqack_q  <= 1'b0;
      respcyc_q <= 1'b0;
      resp_q    <= '0;
      resptag_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus_reqcyc && is_mem_req) begin
            base_q   <= req_base;
            tag_q    <= bus_reqtag;
            reqack_q <= 1'b1;
            state    <= ACK;
          end
        end

        ACK: begin
          reqack_q <= 1'b0;
          beat     <= '0;
          lat_cnt  <= '0;
          if (!tag_q[TAG_RW_BIT]) begin
            state <= WDATA;
          end else if (RESP_LATENCY == 1) begin
            state     <= RDATA;
            respcyc_q <= 1'b1;
            resp_q    <= rd_data;
            resptag_q <= tag_q;
          end else begin
            state <= LAT;
          end
        end

        // ACK already used one latency cycle, so LAT lasts RESP_LATENCY-1.
        LAT: begin
          if (lat_cnt == LAT_W'(RESP_LATENCY - 2)) begin
            state     <= RDATA;
            respcyc_q <= 1'b1;
            resp_q    <= rd_data;
            resptag_q <= tag_q;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end

        RDATA: begin
          if (bus_respack) begin
            if (beat == 3'(BEATS_PER_LINE - 1)) begin
              state     <= IDLE;
              beat      <= '0;
              respcyc_q <= 1'b0;
              resp_q    <= '0;
              resptag_q <= '0;
            end else begin
              beat   <= beat + 1'b1;
              resp_q <= rd_data;
            end
          end
        end

        WDATA: begin
          if (bus_reqcyc) begin
            if (beat == 3'(BEATS_PER_LINE - 1)) begin
              state <= IDLE;
              beat  <= '0;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Write beats are acknowledged combinationally so the requester can stream.
  assign bus_reqack  = reqack_q | wr_en;
  assign bus_respcyc = respcyc_q;
  assign bus_resp    = resp_q;
  assign bus_resptag = resptag_q;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb/tb_sysbus_mem_responder.sv - scoreboard bench for sysbus_mem_responder
module tb_sysbus_mem_responder;

  localparam int         LAT      = 4;
  localparam logic [3:0] MEM_DEV  = 4'h1;
  localparam logic [3:0] OTHER_DEV = 4'h2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        bus_reqcyc = 1'b0;
  logic [63:0] bus_req = '0;
  logic [12:0] bus_reqtag = '0;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        bus_respack = 1'b0;

  sysbus_mem_responder #(
    .BUS_DATA_WIDTH (64),
    .BUS_TAG_WIDTH  (13),
    .MEM_WORDS      (4096),
    .RESP_LATENCY   (LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_reqcyc  (bus_reqcyc),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_reqack  (bus_reqack),
    .bus_respcyc (bus_respcyc),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag),
    .bus_respack (bus_respack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [12:0] tag;
  } beat_t;

  beat_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int popped = 0;
  int stall_beat = -1;
  int stall_left = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the presented beat against the queue head every cycle
  // (so a stalled beat must hold), then decides respack and pops on accept.
  initial begin
    forever begin
      @(negedge clk);
      if (bus_respcyc) begin
        if (exp_q.size() == 0) begin
          check("unexpected_respcyc", 64'(bus_respcyc), 64'd0);
          bus_respack = 1'b1;
        end else begin
          check("resp_data", bus_resp, exp_q[0].data);
          check("resp_tag", 64'(bus_resptag), 64'(exp_q[0].tag));
          if (stall_left > 0 && popped == stall_beat) begin
            bus_respack = 1'b0;
            stall_left--;
          end else begin
            bus_respack = 1'b1;
            void'(exp_q.pop_front());
            popped++;
          end
        end
      end else begin
        // Acks with no beat presented must be ignored.
        bus_respack = 1'b1;
      end
    end
  end

  task automatic push_line(input logic [12:0] tag, input logic [63:0] words[8]);
    beat_t b;
    for (int k = 0; k < 8; k++) begin
      b.data = words[k];
      b.tag  = tag;
      exp_q.push_back(b);
    end
  endtask

  task automatic issue_req(input logic [63:0] addr, input logic [12:0] tag, output int n);
    @(negedge clk);
    bus_reqcyc = 1'b1;
    bus_req    = addr;
    bus_reqtag = tag;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!bus_reqack && n < 10);
    bus_reqcyc = 1'b0;
    bus_req    = '0;
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [7:0] id, input logic [63:0] words[8]);
    int n;
    int acks;
    issue_req(addr, {1'b0, MEM_DEV, id}, n);
    check("wr_reqack_delay", 64'(n), 64'd1);
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus_reqcyc = 1'b1;
      bus_req    = words[k];
      #1;
      if (bus_reqack) acks++;
    end
    @(negedge clk);
    bus_reqcyc = 1'b0;
    bus_req    = '0;
    #1;
    check("wr_beat_acks", 64'(acks), 64'd8);
    check("wr_idle_reqack", 64'(bus_reqack), 64'd0);
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [7:0] id,
                         input logic [63:0] words[8], input int stall_at, input int stall_n);
    int n;
    int m;
    int extra_ack;
    logic [12:0] tag;
    tag        = {1'b1, MEM_DEV, id};
    popped     = 0;
    stall_beat = stall_at;
    stall_left = stall_n;
    push_line(tag, words);
    issue_req(addr, tag, n);
    check("rd_reqack_delay", 64'(n), 64'd1);
    m = 0;
    extra_ack = 0;
    do begin
      @(negedge clk);
      #1;
      m++;
      if (bus_reqack) extra_ack++;
    end while (!bus_respcyc && m < 20);
    check("rd_first_beat_latency", 64'(m), 64'(LAT));
    check("rd_reqack_one_cycle", 64'(extra_ack), 64'd0);
    m = 0;
    while (exp_q.size() != 0 && m < 200) begin
      @(negedge clk);
      #1;
      m++;
    end
    check("rd_drain_timeout", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    #1;
    check("rd_beats_total", 64'(popped), 64'd8);
    check("rd_respcyc_low_after", 64'(bus_respcyc), 64'd0);
    stall_left = 0;
  endtask

  logic [63:0] line_a[8];
  logic [63:0] line_b[8];
  logic [63:0] line_z[8];

  initial begin
    int n;
    int acks;
    for (int k = 0; k < 8; k++) begin
      line_a[k] = 64'((k + 1) * 'h11);
      line_b[k] = 64'h0123_4567_89ab_cd00 + 64'(k);
      line_z[k] = 64'd0;
    end

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_reqack", 64'(bus_reqack), 64'd0);
    check("rst_respcyc", 64'(bus_respcyc), 64'd0);
    check("rst_resp", bus_resp, 64'd0);
    check("rst_resptag", 64'(bus_resptag), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Write line 0x1000 with 0x11..0x88, then read back via a mid-line address
    do_write(64'h1000, 8'h00, line_a);
    do_read(64'h1008, 8'h00, line_a, -1, 0);

    // Requester stalls 3 cycles on beat 2
    do_read(64'h1000, 8'h05, line_a, 2, 3);

    // Foreign device: never acknowledged, never answered
    @(negedge clk);
    bus_reqcyc = 1'b1;
    bus_req    = 64'h1000;
    bus_reqtag = {1'b1, OTHER_DEV, 8'h07};
    acks = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (bus_reqack) acks++;
    end
    bus_reqcyc = 1'b0;
    check("foreign_reqack_count", 64'(acks), 64'd0);

    // Reset during beat 4 of a read aborts the burst
    popped = 0;
    push_line({1'b1, MEM_DEV, 8'h09}, line_a);
    issue_req(64'h1000, {1'b1, MEM_DEV, 8'h09}, n);
    n = 0;
    while (popped < 5 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("abort_reached_beat4", 64'(popped), 64'd5);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("abort_respcyc", 64'(bus_respcyc), 64'd0);
    check("abort_resp", bus_resp, 64'd0);
    check("abort_resptag", 64'(bus_resptag), 64'd0);
    exp_q.delete();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    do_read(64'h1000, 8'h0a, line_a, -1, 0);

    // Address wrap: line 0 aliases address MEM_WORDS*8; unwritten line reads 0
    do_write(64'h0, 8'h11, line_b);
    do_read(64'h8000, 8'h12, line_b, -1, 0);
    do_read(64'h2000, 8'h13, line_z, -1, 0);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sysbus_mem_responder.md
SYSBUS_MEM_RESPONDER -- requirements
Module: sysbus_mem_responder

Interface
REQ-001 Parameter BUS_DATA_WIDTH, default 64, SHALL set the data/address bus width.
REQ-002 Parameter BUS_TAG_WIDTH, default 13, SHALL set the tag width.
REQ-003 Parameter MEM_WORDS, default 4096, SHALL set the backing-store depth in 64-bit words (power of 2, >=8).
REQ-004 Parameter RESP_LATENCY, default 4, SHALL set cycles from end of request acknowledge to first read beat (>=1).
REQ-005 clk  input  1  clock; all logic on posedge.
REQ-006 reset  input  1  reset, synchronous, active-low.
REQ-007 bus_reqcyc  input  1  request/write-data valid from the requester.
REQ-008 bus_req  input  BUS_DATA_WIDTH  request address, or write data during a write burst.
REQ-009 bus_reqtag  input  BUS_TAG_WIDTH  request tag: [12] 1=read, 0=write; [11:8] device; [7:0] id.
REQ-010 bus_reqack  output  1  request/write-beat accepted.
REQ-011 bus_respcyc  output  1  read-response beat valid.
REQ-012 bus_resp  output  BUS_DATA_WIDTH  read-response data.
REQ-013 bus_resptag  output  BUS_TAG_WIDTH  tag of the burst being returned.
REQ-014 bus_respack  input  1  requester consumed current response beat.

Function
REQ-015 The block SHALL serve only requests whose tag[11:8] equals SYSBUS_MEMORY; other requests SHALL get no reqack and no response.
REQ-016 A line is 8 beats of 64 bits; address bits [5:0] SHALL be ignored; beat k word index = (addr[63:6]*8 + k) mod MEM_WORDS.
REQ-017 FSM states SHALL be IDLE, ACK, LAT, RDATA, WDATA.
REQ-018 IDLE: on bus_reqcyc=1 with a memory tag, capture address and tag; next state ACK.
REQ-019 ACK: bus_reqack=1 for exactly one cycle; reqcyc ignored; next LAT if tag[12]=1, else WDATA.
REQ-020 LAT: counter SHALL run RESP_LATENCY-1 further cycles, so first respcyc is RESP_LATENCY cycles after the ACK cycle; then RDATA, beat=0.
REQ-021 RDATA: bus_respcyc=1, bus_resp=mem[beat word], bus_resptag=captured tag; all three SHALL hold stable until bus_respack=1 is sampled.
REQ-022 RDATA: respack=1 sampled SHALL advance beat; on beat 7 acked, next state IDLE with respcyc=0 next cycle.
REQ-023 WDATA: bus_reqack SHALL equal bus_reqcyc combinationally; each cycle with reqcyc=1 SHALL write bus_req to mem[beat word] at the clock edge and advance beat; after beat 7 next state IDLE; no response SHALL be issued.
REQ-024 bus_respack while respcyc=0, and reqcyc outside IDLE/WDATA, SHALL be ignored.
REQ-025 Beat counter SHALL be 3 bits; word index wrap SHALL be modulo MEM_WORDS.
REQ-026 bus_reqack SHALL be 0 in IDLE, LAT, RDATA.
REQ-027 Read of a word never written SHALL return 0.

Reset
REQ-028 While reset=0 at a clock edge: state IDLE, beat and latency counters 0, captured tag/address 0.
REQ-029 Outputs during/after reset: bus_reqack=0, bus_respcyc=0, bus_resp=0, bus_resptag=0.
REQ-030 Reset mid-burst SHALL abort the burst with no further beats; memory contents SHALL be retained (memory zeroed only at time 0).

Structure
REQ-031 Shared package sysbus_pkg SHALL hold the state enum, BEATS_PER_LINE=8, and tag-field bit positions; SYSBUS_MEMORY SHALL come from Sysbus.defs.
REQ-032 One sub-module sysbus_mem_array (MEM_WORDS x 64, one sync write port, one async read port) SHALL hold storage.

Verification
REQ-033 Write burst addr 0x1000, tag {0,MEM,0x00}, data 0x11..0x88 back-to-back -> reqack 1 cycle after capture, 8 write acks, no respcyc.
REQ-034 Read burst addr 0x1008, tag {1,MEM,0x00}, RESP_LATENCY=4 -> reqack one cycle, first respcyc 4 cycles later, beats 0x11..0x88 in order, resptag echoed.
REQ-035 Read with respack held low 3 cycles on beat 2 -> resp/resptag stable, beat 3 only after ack, exactly 8 beats total.
REQ-036 Request tag device != SYSBUS_MEMORY -> reqack never asserts, FSM stays IDLE for 20 cycles.
REQ-037 reset=0 during beat 4 of a read -> next cycle respcyc=0, IDLE; new read of 0x1000 returns original data.
REQ-038 Read of address 0x(MEM_WORDS*8) -> data of word 0 (wrap), unwritten words return 0.
